// File: rtl/blaster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blaster_pkg: shared types and constants for the JTAG shift engine.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package blaster_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    RESULT = 2'd3
  } shift_state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int TCK_HALF_MIN  = 2;

endpackage
`default_nettype wire

// File: rtl/blaster_jtag_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blaster_jtag_shifter_if: byte stream, result stream and JTAG pins.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface blaster_jtag_shifter_if;
  import blaster_pkg::*;

  logic [BITS_PER_BYTE-1:0] i_byte;
  logic                     i_read;
  logic                     i_tms;
  logic                     i_valid;
  logic                     o_ready;
  logic [BITS_PER_BYTE-1:0] o_rd_byte;
  logic                     o_rd_valid;
  logic                     i_rd_ready;
  logic                     o_tck;
  logic                     o_tdi;
  logic                     o_tms;
  logic                     i_tdo;
  logic                     o_busy;

  modport slave (
    input  i_byte, i_read, i_tms, i_valid, i_rd_ready, i_tdo,
    output o_ready, o_rd_byte, o_rd_valid, o_tck, o_tdi, o_tms, o_busy
  );

  modport master (
    output i_byte, i_read, i_tms, i_valid, i_rd_ready, i_tdo,
    input  o_ready, o_rd_byte, o_rd_valid, o_tck, o_tdi, o_tms, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/blaster_jtag_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blaster_jtag_shifter: shifts one byte LSB-first over JTAG, optional  |
// | TDO capture returned as a result byte. Revision: 1.0                 |
// +----------------------------------------------------------------------+
module blaster_jtag_shifter
  import blaster_pkg::*;
#(
  parameter int TCK_HALF_CLKS = 2
) (
  input  wire logic              i_clk,
  input  wire logic              i_reset_n,
  blaster_jtag_shifter_if.slave  bus
);

  localparam int                  c_HALF_W      = $clog2(TCK_HALF_CLKS);
  localparam logic [c_HALF_W-1:0] c_HALF_RELOAD = c_HALF_W'(TCK_HALF_CLKS - 1);
  localparam logic [2:0]          c_LAST_BIT    = 3'(BITS_PER_BYTE - 1);

  generate
    if (TCK_HALF_CLKS < TCK_HALF_MIN) begin : g_bad_half
      $error("TCK_HALF_CLKS must be at least 2");
    end
  endgenerate

  shift_state_t             r_state;
  shift_state_t             w_state_next;
  logic                     w_accept;
  logic                     w_half_done;
  logic [c_HALF_W-1:0]      r_half;
  logic [2:0]               r_bit_cnt;
  logic [BITS_PER_BYTE-1:0] r_sh;
  logic [BITS_PER_BYTE-1:0] r_cap;
  logic [BITS_PER_BYTE-1:0] r_rd_byte;
  logic                     r_rd;
  logic                     r_tdo;
  logic                     r_tck;
  logic                     r_tdi;
  logic                     r_tms;
  logic                     r_rd_valid;

  assign w_half_done = (r_half == '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_valid) begin
          w_accept     = 1'b1;
          w_state_next = LOW;
        end
      end
      LOW: begin
        if (w_half_done) w_state_next = HIGH;
      end
      HIGH: begin
        if (w_half_done) begin
          if (r_bit_cnt != c_LAST_BIT) w_state_next = LOW;
          else if (r_rd)               w_state_next = RESULT;
          else                         w_state_next = IDLE;
        end
      end
      RESULT: begin
        if (bus.i_rd_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath follows the same phase-completion events the FSM decodes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_half     <= '0;
      r_bit_cnt  <= '0;
      r_sh       <= '0;
      r_cap      <= '0;
      r_rd_byte  <= '0;
      r_rd       <= 1'b0;
      r_tdo      <= 1'b0;
      r_tck      <= 1'b0;
      r_tdi      <= 1'b0;
      r_tms      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_tdo <= bus.i_tdo;
      if (w_accept) begin
        r_sh      <= bus.i_byte;
        r_rd      <= bus.i_read;
        r_tms     <= bus.i_tms;
        r_bit_cnt <= '0;
        r_tdi     <= bus.i_byte[0];
        r_half    <= c_HALF_RELOAD;
      end else begin
        case (r_state)
          IDLE: r_tms <= bus.i_tms;
          LOW: begin
            if (w_half_done) begin
              r_tck            <= 1'b1;
              r_half           <= c_HALF_RELOAD;
              r_cap[r_bit_cnt] <= r_tdo;
            end else begin
              r_half <= r_half - 1'b1;
            end
          end
          HIGH: begin
            if (w_half_done) begin
              r_tck  <= 1'b0;
              r_half <= c_HALF_RELOAD;
              if (r_bit_cnt != c_LAST_BIT) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_tdi     <= r_sh[r_bit_cnt + 3'd1];
              end else if (r_rd) begin
                r_rd_byte  <= r_cap;
                r_rd_valid <= 1'b1;
              end
            end else begin
              r_half <= r_half - 1'b1;
            end
          end
          RESULT: begin
            if (bus.i_rd_ready) r_rd_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_ready    = (r_state == IDLE);
  assign bus.o_busy     = (r_state != IDLE);
  assign bus.o_tck      = r_tck;
  assign bus.o_tdi      = r_tdi;
  assign bus.o_tms      = r_tms;
  assign bus.o_rd_byte  = r_rd_byte;
  assign bus.o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire
